// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared types, opcodes and operand snoop helper for the ALU reservation station
package alu_rs_pkg;

   localparam int ROB_BIT = 4;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic               busy;
      logic [2:0]         op;
      logic [6:0]         op_type;
      logic               op_addition;
      logic [31:0]        vi;
      logic [31:0]        vj;
      logic               qi_valid;
      logic [ROB_BIT-1:0] qi;
      logic               qj_valid;
      logic [ROB_BIT-1:0] qj;
      logic [ROB_BIT-1:0] rob_entry;
   } rs_entry_t;

   function automatic logic opc_supported(input logic [6:0] opc);
      return (opc == OPC_OP_IMM) || (opc == OPC_OP) || (opc == OPC_BRANCH);
   endfunction

   // Returns {still_pending, value}; the ALU bus wins if both buses carry the tag.
   function automatic logic [32:0] operand_snoop(
      input logic               q_valid,
      input logic [ROB_BIT-1:0] q,
      input logic [31:0]        v,
      input logic               a_valid,
      input logic [ROB_BIT-1:0] a_rob,
      input logic [31:0]        a_val,
      input logic               l_valid,
      input logic [ROB_BIT-1:0] l_rob,
      input logic [31:0]        l_val
   );
      if (q_valid && a_valid && (a_rob == q)) return {1'b0, a_val};
      if (q_valid && l_valid && (l_rob == q)) return {1'b0, l_val};
      return {q_valid, v};
   endfunction

endpackage

// File: rtl/alu_rs_select.sv
// rtl/alu_rs_select.sv - ready vector to one-hot issue grant; oldest-first when ALU_RS_AGE_ORDER_EN is defined
module alu_rs_select
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE = 8
) (
   input  logic [RS_SIZE-1:0]         ready_i,
`ifdef ALU_RS_AGE_ORDER_EN
   input  logic [RS_SIZE*RS_SIZE-1:0] age_i,
`endif
   output logic [RS_SIZE-1:0]         grant_o
);

`ifdef ALU_RS_AGE_ORDER_EN
   // age_i[j*RS_SIZE+i] set means entry j was dispatched before entry i.
   always_comb begin
      grant_o = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         grant_o[i] = ready_i[i];
         for (int j = 0; j < RS_SIZE; j++) begin
            if ((j != i) && ready_i[j] && age_i[j*RS_SIZE+i]) grant_o[i] = 1'b0;
         end
      end
   end
`else
   logic found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (ready_i[i] && !found) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station with CDB snooping and single issue; ALU_RS_AGE_ORDER_EN selects oldest-first issue
module alu_rs #(
   parameter int RS_SIZE = 8,
   parameter int ROB_BIT = 4
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               rob_clear_up,
   input  logic               disp_valid,
   input  logic [2:0]         disp_op,
   input  logic [6:0]         disp_op_type,
   input  logic               disp_op_addition,
   input  logic [31:0]        disp_vi,
   input  logic [31:0]        disp_vj,
   input  logic               disp_qi_valid,
   input  logic               disp_qj_valid,
   input  logic [ROB_BIT-1:0] disp_qi,
   input  logic [ROB_BIT-1:0] disp_qj,
   input  logic [ROB_BIT-1:0] disp_rob_entry,
   output logic               full,
   input  logic               alu_cdb_valid,
   input  logic [ROB_BIT-1:0] alu_cdb_rob,
   input  logic [31:0]        alu_cdb_val,
   input  logic               lsb_cdb_valid,
   input  logic [ROB_BIT-1:0] lsb_cdb_rob,
   input  logic [31:0]        lsb_cdb_val,
   output logic               alu_valid,
   output logic [31:0]        alu_vi,
   output logic [31:0]        alu_vj,
   output logic [2:0]         alu_op,
   output logic [6:0]         alu_op_type,
   output logic               alu_op_addition,
   output logic [ROB_BIT-1:0] alu_rob_entry
);
   import alu_rs_pkg::*;

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
   localparam int CNT_W = $clog2(RS_SIZE + 1);

   rs_entry_t          ent_q [RS_SIZE];
   rs_entry_t          ent_d [RS_SIZE];
   rs_entry_t          new_ent;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               full_q, full_d;
   logic               alu_valid_q, alu_valid_d;
   logic [31:0]        alu_vi_q, alu_vi_d;
   logic [31:0]        alu_vj_q, alu_vj_d;
   logic [2:0]         alu_op_q, alu_op_d;
   logic [6:0]         alu_op_type_q, alu_op_type_d;
   logic               alu_op_addition_q, alu_op_addition_d;
   logic [ROB_BIT-1:0] alu_rob_entry_q, alu_rob_entry_d;

   logic [RS_SIZE-1:0] ready;
   logic [RS_SIZE-1:0] grant;
   logic [IDX_W-1:0]   grant_idx, free_idx;
   logic               grant_any, free_any, disp_acc;

`ifdef ALU_RS_AGE_ORDER_EN
   logic [RS_SIZE*RS_SIZE-1:0] age_q, age_d;
`endif

   // Readiness uses registered state only, so a wakeup costs one edge before issue.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         ready[i] = ent_q[i].busy && !ent_q[i].qi_valid && !ent_q[i].qj_valid;
      end
   end

   alu_rs_select #(
      .RS_SIZE (RS_SIZE)
   ) u_select (
      .ready_i (ready),
`ifdef ALU_RS_AGE_ORDER_EN
      .age_i   (age_q),
`endif
      .grant_o (grant)
   );

   always_comb begin
      grant_idx = '0;
      grant_any = |grant;
      free_idx  = '0;
      free_any  = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (grant[i]) grant_idx = IDX_W'(i);
      end
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!ent_q[i].busy) begin
            free_idx = IDX_W'(i);
            free_any = 1'b1;
         end
      end
   end

   always_comb begin
      ent_d             = ent_q;
      cnt_d             = cnt_q;
      full_d            = full_q;
      alu_valid_d       = alu_valid_q;
      alu_vi_d          = alu_vi_q;
      alu_vj_d          = alu_vj_q;
      alu_op_d          = alu_op_q;
      alu_op_type_d     = alu_op_type_q;
      alu_op_addition_d = alu_op_addition_q;
      alu_rob_entry_d   = alu_rob_entry_q;
      disp_acc          = 1'b0;
      new_ent           = '0;
`ifdef ALU_RS_AGE_ORDER_EN
      age_d             = age_q;
`endif
      if (rob_clear_up) begin
         for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
         cnt_d       = '0;
         full_d      = 1'b0;
         alu_valid_d = 1'b0;
      end else if (rdy_in) begin
         alu_valid_d = grant_any;
         if (grant_any) begin
            alu_vi_d               = ent_q[grant_idx].vi;
            alu_vj_d               = ent_q[grant_idx].vj;
            alu_op_d               = ent_q[grant_idx].op;
            alu_op_type_d          = ent_q[grant_idx].op_type;
            alu_op_addition_d      = ent_q[grant_idx].op_addition;
            alu_rob_entry_d        = ent_q[grant_idx].rob_entry;
            ent_d[grant_idx].busy  = 1'b0;
         end

         for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_d[i].busy) begin
               {ent_d[i].qi_valid, ent_d[i].vi} = operand_snoop(
                  ent_d[i].qi_valid, ent_d[i].qi, ent_d[i].vi,
                  alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                  lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
               {ent_d[i].qj_valid, ent_d[i].vj} = operand_snoop(
                  ent_d[i].qj_valid, ent_d[i].qj, ent_d[i].vj,
                  alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                  lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
            end
         end

         // The slot freed by this edge's issue is not offered to dispatch until the next edge.
         if (disp_valid && !full_q && free_any) begin
            disp_acc            = 1'b1;
            new_ent.busy        = 1'b1;
            new_ent.op          = disp_op;
            new_ent.op_type     = disp_op_type;
            new_ent.op_addition = disp_op_addition;
            new_ent.qi          = disp_qi;
            new_ent.qj          = disp_qj;
            new_ent.rob_entry   = disp_rob_entry;
            {new_ent.qi_valid, new_ent.vi} = operand_snoop(
               disp_qi_valid, disp_qi, disp_vi,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
            {new_ent.qj_valid, new_ent.vj} = operand_snoop(
               disp_qj_valid, disp_qj, disp_vj,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
            ent_d[free_idx] = new_ent;
`ifdef ALU_RS_AGE_ORDER_EN
            for (int j = 0; j < RS_SIZE; j++) begin
               age_d[int'(free_idx)*RS_SIZE + j] = 1'b0;
               age_d[j*RS_SIZE + int'(free_idx)] = (j != int'(free_idx));
            end
`endif
         end

         cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, disp_acc} - {{(CNT_W-1){1'b0}}, grant_any};
         full_d = (cnt_d == CNT_W'(RS_SIZE));
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
         cnt_q             <= '0;
         full_q            <= 1'b0;
         alu_valid_q       <= 1'b0;
         alu_vi_q          <= '0;
         alu_vj_q          <= '0;
         alu_op_q          <= '0;
         alu_op_type_q     <= '0;
         alu_op_addition_q <= 1'b0;
         alu_rob_entry_q   <= '0;
      end else begin
         ent_q             <= ent_d;
         cnt_q             <= cnt_d;
         full_q            <= full_d;
         alu_valid_q       <= alu_valid_d;
         alu_vi_q          <= alu_vi_d;
         alu_vj_q          <= alu_vj_d;
         alu_op_q          <= alu_op_d;
         alu_op_type_q     <= alu_op_type_d;
         alu_op_addition_q <= alu_op_addition_d;
         alu_rob_entry_q   <= alu_rob_entry_d;
      end
   end

`ifdef ALU_RS_AGE_ORDER_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) age_q <= '0;
      else         age_q <= age_d;
   end
`endif

   assign full            = full_q;
   assign alu_valid       = alu_valid_q;
   assign alu_vi          = alu_vi_q;
   assign alu_vj          = alu_vj_q;
   assign alu_op          = alu_op_q;
   assign alu_op_type     = alu_op_type_q;
   assign alu_op_addition = alu_op_addition_q;
   assign alu_rob_entry   = alu_rob_entry_q;

   assert property (@(posedge clk_in) disable iff (!rst_in)
      !(disp_valid && full_q && rdy_in && !rob_clear_up))
      else $warning("alu_rs: dispatch while full dropped");

   assert property (@(posedge clk_in) disable iff (!rst_in)
      (disp_valid && !full_q && rdy_in && !rob_clear_up) |-> opc_supported(disp_op_type))
      else $warning("alu_rs: unsupported opcode dispatched");

endmodule
